// File: rtl/nbit_sar_search_pkg.sv
// Shared types and constants for the signed successive-approximation search engine.
// Holds the FSM state encoding, the default operand width and the sign-bit mask.
package nbit_sar_search_pkg;

  localparam int N_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [N_DEF-1:0] MSB_MASK = {1'b1, {(N_DEF-1){1'b0}}};

endpackage

// File: rtl/nbit_sar_search_if.sv
// Bus between the search engine and its comparator/controller side.
// Handshake: cmp_lt is consumed only on an edge where cmp_valid=1; guess stays stable until then.
interface nbit_sar_search_if import nbit_sar_search_pkg::*; #(parameter int N = N_DEF) ();

  logic         start;
  logic         cmp_valid;
  logic         cmp_lt;
  logic [N-1:0] guess;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  state_e       state;

  modport master (
    output start, cmp_valid, cmp_lt,
    input  guess, busy, done, result, state
  );

  modport slave (
    input  start, cmp_valid, cmp_lt,
    output guess, busy, done, result, state
  );

endinterface

// File: rtl/nbit_sar_search.sv
// Signed SAR search: turns a stream of signed less-than verdicts back into the target operand.
// Searches in offset binary (u), so unsigned bisection on u equals signed bisection on guess.
module nbit_sar_search import nbit_sar_search_pkg::*; #(
  parameter int N = N_DEF
) (
  input  logic             clk,
  input  logic             rst,
  nbit_sar_search_if.slave bus
);

  localparam int           KW  = $clog2(N);
  localparam logic [N-1:0] MSB = {1'b1, {(N-1){1'b0}}};

  state_e          state_q, state_d;
  logic [N-1:0]    u_q, u_d;
  logic [N-1:0]    guess_q, guess_d;
  logic [N-1:0]    result_q, result_d;
  logic [KW-1:0]   k_q, k_d;
  logic [N-1:0]    u_tmp;

  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    k_d      = k_q;
    guess_d  = guess_q;
    result_d = result_q;
    u_tmp    = u_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SEARCH;
          u_d     = MSB;
          k_d     = KW'(N-1);
          guess_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (bus.cmp_valid) begin
          if (bus.cmp_lt) u_tmp[k_q] = 1'b0;
          if (k_q != '0) begin
            u_tmp[k_q - KW'(1)] = 1'b1;
            k_d                 = k_q - KW'(1);
          end else begin
            result_d = u_tmp ^ MSB;
            state_d  = DONE;
          end
          u_d     = u_tmp;
          guess_d = u_tmp ^ MSB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      u_q      <= '0;
      k_q      <= KW'(N-1);
      guess_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      u_q      <= u_d;
      k_q      <= k_d;
      guess_q  <= guess_d;
      result_q <= result_d;
    end
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = (state_q == SEARCH);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_nbit_sar_search.sv
// Directed bench for nbit_sar_search: the loop is closed with a behavioural signed comparator.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_nbit_sar_search;
  import nbit_sar_search_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] target;
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         hold_viol;
  logic [7:0] guess_log[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  nbit_sar_search_if #(.N(8)) bus ();

  assign bus.cmp_lt = ($signed(target) < $signed(bus.guess));

  nbit_sar_search #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // mode 0: verdict every cycle, 1: stall on every other cycle, 2: random stalls
  task automatic run_search(input logic [7:0] tgt, input int mode,
                            output int busy_cyc, output int done_cnt, output logic [7:0] res);
    logic [7:0] prev_g;
    bit         prev_stall;
    busy_cyc = 0; done_cnt = 0; res = '0;
    prev_g = '0; prev_stall = 1'b0; hold_viol = 0;
    guess_log.delete();
    @(negedge clk);
    target = tgt; bus.start = 1'b1; bus.cmp_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bus.done) begin
        done_cnt++;
        res = bus.result;
        break;
      end
      if (bus.busy) begin
        if (prev_stall && bus.guess !== prev_g) hold_viol++;
        case (mode)
          0:       bus.cmp_valid = 1'b1;
          1:       bus.cmp_valid = (busy_cyc % 2 == 1);
          default: bus.cmp_valid = ($urandom_range(0, 2) != 0);
        endcase
        busy_cyc++;
        if (bus.cmp_valid) guess_log.push_back(bus.guess);
        prev_stall = !bus.cmp_valid;
        prev_g     = bus.guess;
      end
      @(negedge clk);
    end
    bus.cmp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.cmp_valid = 1'b0; target = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", bus.state, IDLE); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.guess !== 8'h00) begin n_fail++; $display("FAIL reset_guess: got %h expected 00", bus.guess); end
    n_cmp++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h expected 00", bus.result); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int bc, dc;
    logic [7:0] res;
    exp_q = '{8'h00, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFA, 8'hFB};
    run_search(8'hFB, 0, bc, dc, res);
    n_cmp++; if (guess_log.size() !== 8) begin n_fail++; $display("FAIL dir_guess_count: got %0d expected 8", guess_log.size()); end
    for (int i = 0; i < guess_log.size() && exp_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (guess_log[i] !== e) begin n_fail++; $display("FAIL dir_guess[%0d]: got %h expected %h", i, guess_log[i], e); end
    end
    n_cmp++; if (bc !== 8) begin n_fail++; $display("FAIL dir_search_cycles: got %0d expected 8", bc); end
    n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL dir_done: got %0d expected 1", dc); end
    n_cmp++; if (res !== 8'hFB) begin n_fail++; $display("FAIL dir_result: got %h expected fb", res); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir_done_pulse: got %b expected 0", bus.done); end
    n_cmp++; if (bus.result !== 8'hFB) begin n_fail++; $display("FAIL dir_result_held: got %h expected fb", bus.result); end
  endtask

  task automatic test_extremes();
    logic [7:0] tv[3];
    int bc, dc;
    logic [7:0] res;
    tv = '{8'h7F, 8'h80, 8'h00};
    foreach (tv[i]) begin
      run_search(tv[i], 0, bc, dc, res);
      n_cmp++; if (res !== tv[i]) begin n_fail++; $display("FAIL ext_result: got %h expected %h", res, tv[i]); end
      n_cmp++; if (bc !== 8) begin n_fail++; $display("FAIL ext_cycles(%h): got %0d expected 8", tv[i], bc); end
      n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL ext_done(%h): got %0d expected 1", tv[i], dc); end
    end
  endtask

  task automatic test_stalls();
    int bc, dc;
    logic [7:0] res;
    run_search(8'h25, 1, bc, dc, res);
    n_cmp++; if (res !== 8'h25) begin n_fail++; $display("FAIL stall_result: got %h expected 25", res); end
    n_cmp++; if (bc !== 16) begin n_fail++; $display("FAIL stall_cycles: got %0d expected 16", bc); end
    n_cmp++; if (hold_viol !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes expected 0", hold_viol); end
    n_cmp++; if (guess_log.size() !== 8) begin n_fail++; $display("FAIL stall_verdicts: got %0d expected 8", guess_log.size()); end
  endtask

  task automatic test_back_to_back();
    int bc;
    bit seen_done;
    @(negedge clk);
    target = 8'h3A; bus.start = 1'b1; bus.cmp_valid = 1'b1;
    @(negedge clk);
    bc = 0; seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) begin seen_done = 1'b1; break; end
      if (bus.busy) bc++;
      bus.start = (bc < 5);
      @(negedge clk);
    end
    n_cmp++; if (!seen_done) begin n_fail++; $display("FAIL b2b_first_done: got none expected pulse"); end
    n_cmp++; if (bc !== 8) begin n_fail++; $display("FAIL b2b_first_cycles: got %0d expected 8", bc); end
    n_cmp++; if (bus.result !== 8'h3A) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 3a", bus.result); end
    target = 8'h11; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_busy: got %b expected 1", bus.busy); end
    n_cmp++; if (bus.guess !== 8'h00) begin n_fail++; $display("FAIL b2b_restart_guess: got %h expected 00", bus.guess); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_restart_done: got %b expected 0", bus.done); end
    bc = 0; seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.done) begin seen_done = 1'b1; break; end
      if (bus.busy) bc++;
      @(negedge clk);
    end
    bus.cmp_valid = 1'b0;
    n_cmp++; if (!seen_done || bc !== 8) begin n_fail++; $display("FAIL b2b_second_cycles: got %0d done=%b expected 8 done=1", bc, seen_done); end
    n_cmp++; if (bus.result !== 8'h11) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 11", bus.result); end
  endtask

  task automatic test_reset_mid();
    int bc, dc;
    logic [7:0] res;
    @(negedge clk);
    target = 8'h55; bus.start = 1'b1; bus.cmp_valid = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bc = 0;
    for (int c = 0; c < 20 && bc < 4; c++) begin
      if (bus.busy) bc++;
      if (bc < 4) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.result !== 8'h00) begin n_fail++; $display("FAIL rstmid_result: got %h expected 00", bus.result); end
    n_cmp++; if (bus.guess !== 8'h00) begin n_fail++; $display("FAIL rstmid_guess: got %h expected 00", bus.guess); end
    rst = 1'b0; bus.cmp_valid = 1'b0;
    run_search(8'h9C, 0, bc, dc, res);
    n_cmp++; if (res !== 8'h9C) begin n_fail++; $display("FAIL rstmid_next_result: got %h expected 9c", res); end
    n_cmp++; if (bc !== 8) begin n_fail++; $display("FAIL rstmid_next_cycles: got %0d expected 8", bc); end
  endtask

  task automatic test_random();
    int bc, dc;
    logic [7:0] res, tgt;
    for (int i = 0; i < 1000; i++) begin
      tgt = 8'($urandom_range(0, 255));
      run_search(tgt, 2, bc, dc, res);
      n_cmp++; if (res !== tgt) begin n_fail++; $display("FAIL rand_result[%0d]: got %h expected %h", i, res, tgt); end
      n_cmp++; if (dc !== 1 || guess_log.size() !== 8) begin n_fail++; $display("FAIL rand_done[%0d]: got done=%0d verdicts=%0d expected 1/8", i, dc, guess_log.size()); end
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rand_pulse[%0d]: got %b expected 0", i, bus.done); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_extremes();
    test_stalls();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
